muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Parametrised iterative multiply/divide unit that computes the HI/LO pair for signed and unsigned MULT/DIV in one shared datapath. It sits between the A/B operand registers and the HI/LO registers of the multicycle CPU and uses a start/busy/done handshake with the control unit. Operand width is a parameter. Divide-by-zero is detected and flagged explicitly rather than producing undefined results.

## Interface
- WIDTH, 32: operand width in bits; legal range 4..64. HI and LO are each WIDTH bits.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  request; sampled only in IDLE
- op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  in  WIDTH  multiplicand / dividend; sampled with start
- b  in  WIDTH  multiplier / divisor; sampled with start
- busy  out  1  high from the accepting edge until the result edge
- done  out  1  one-cycle pulse; HI/LO are valid from this cycle on
- hi  out  WIDTH  MULT: upper product half; DIV: remainder
- lo  out  WIDTH  MULT: lower product half; DIV: quotient
- div_zero  out  1  set with done when a DIV/DIVU had b == 0; cleared on the next accepted start

## Operation
- FSM states: IDLE, RUN, FIX.
  - IDLE, start=1: latch op, sign flags and operand magnitudes. Magnitude is the two's-complement negation when the op is signed and the MSB is set; otherwise the raw value. Load the iteration counter with WIDTH, clear div_zero and move to RUN.
  - IDLE, start=1, divide op with b == 0: go straight to FIX with the zero flag set. No iterations run.
  - RUN: one iteration per clock. The counter decrements each clock; when it reaches 1, move to FIX.
  - FIX: apply sign correction and write hi/lo, pulse done, return to IDLE.
- Multiply: radix-2 shift-add over the magnitudes, producing a 2*WIDTH-bit product register. A signed op whose operand signs differ negates the full 2*WIDTH product. hi = product[2W-1:W], lo = product[W-1:0].
- Divide: restoring division over the magnitudes, with a (WIDTH+1)-bit partial remainder.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Signed most-negative / -1 yields lo = most-negative (wrap) and hi = 0. No overflow flag.
- Divide by zero: hi/lo keep their previous values, div_zero=1 and done pulses.
- hi, lo and div_zero hold their values until the next FIX. They do not change during RUN.
- start while busy (RUN or FIX) is ignored. There is no queueing, and a, b and op may change freely while busy.
- The counter is $clog2(WIDTH+1) bits wide. All internal arithmetic is unsigned on magnitudes; sign handling happens only at latch and FIX.

## Timing
- Reset values: state IDLE; busy=0, done=0, hi=0, lo=0, div_zero=0; counter and internal registers 0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced and the outputs read 0.
- Cycle numbering, with start accepted at edge 0:
  - busy=1 after edge 0.
  - Iterations run at edges 1..WIDTH.
  - FIX is at edge WIDTH+1: hi/lo update, done=1 and busy=0 after this edge.
  - Latency from the accepting edge to done is WIDTH+1 clocks (33 for WIDTH=32).
- Divide by zero: FIX is at edge 1, so done and div_zero=1 appear after edge 1 (latency 1).
- done is high for exactly one cycle. start may be reasserted in the done cycle and is accepted at that edge (back-to-back issue, throughput WIDTH+2 clocks).
- busy and done are never high in the same cycle.

## Test plan
- MULT with a=0xFFFFFFFD (-3), b=7 -> done 33 clocks after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. The same operands under MULT -> hi=0x00000000, lo=0x00000001.
- DIV with a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; div_zero=0.
- DIVU with a=100, b=0, after a prior result hi=5, lo=9 -> done one clock after accept; div_zero=1; hi=5, lo=9 unchanged. The next accepted start clears div_zero.
- Start pulses during RUN with different operands -> ignored, and the first result is unchanged. Assert reset at iteration 10 -> busy, done, hi and lo all 0 immediately. Rerun the bench with WIDTH=8: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01, done after 9 clocks.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Operand/result bundle between the control unit and the iterative multiply/divide unit.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step per clock,
// operating on magnitudes with sign correction applied in a final FIX cycle.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               zero_div;
    logic [WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;

    function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Operand decode at the accepting edge
    logic             op_signed;
    logic             op_div;
    logic             sign_a;
    logic             sign_b;
    logic             b_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign op_signed = ~bus.op[0];
    assign op_div    = bus.op[1];
    assign sign_a    = op_signed & bus.a[WIDTH-1];
    assign sign_b    = op_signed & bus.b[WIDTH-1];
    assign b_zero    = (bus.b == '0);
    assign mag_a     = neg_if(sign_a, bus.a);
    assign mag_b     = neg_if(sign_b, bus.b);

    // One iteration step: multiply adds into the upper half, divide shifts the dividend into rem
    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] rem_diff;

    assign add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, addend} : '0);
    assign rem_sh   = {rem, prod[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, addend};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            is_div       <= 1'b0;
            neg_res      <= 1'b0;
            neg_rem      <= 1'b0;
            zero_div     <= 1'b0;
            addend       <= '0;
            prod         <= '0;
            rem          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.hi       <= '0;
            bus.lo       <= '0;
            bus.div_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div       <= op_div;
                        neg_res      <= sign_a ^ sign_b;
                        neg_rem      <= sign_a;
                        zero_div     <= op_div & b_zero;
                        addend       <= op_div ? mag_b : mag_a;
                        prod         <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
                        rem          <= '0;
                        cnt          <= CNT_INIT;
                        bus.div_zero <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= (op_div && b_zero) ? FIX : RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        // A set borrow bit means the trial subtraction failed: keep the shifted remainder
                        rem              <= rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
                        prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], ~rem_diff[WIDTH]};
                    end else begin
                        prod <= {add_sum, prod[WIDTH-1:1]};
                    end
                    if (cnt == CNT_LAST) state <= FIX;
                end
                FIX: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= IDLE;
                    if (zero_div) begin
                        bus.div_zero <= 1'b1;
                    end else if (is_div) begin
                        bus.lo <= neg_if(neg_res, prod[WIDTH-1:0]);
                        bus.hi <= neg_if(neg_rem, rem);
                    end else begin
                        {bus.hi, bus.lo} <= neg2_if(neg_res, prod);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed and random MULT/DIV operations on a 32-bit and an 8-bit
// instance, compared against an arithmetic reference model.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(32)) b32();
    muldiv_seq_if #(.WIDTH(8))  b8();

    muldiv_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    muldiv_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

    bit          sel8;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] e_hi [0:1];
    logic [63:0] e_lo [0:1];

    logic        m_busy, m_done, m_dz;
    logic [63:0] m_hi, m_lo;
    assign m_busy = sel8 ? b8.busy     : b32.busy;
    assign m_done = sel8 ? b8.done     : b32.done;
    assign m_dz   = sel8 ? b8.div_zero : b32.div_zero;
    assign m_hi   = sel8 ? 64'(b8.hi)  : 64'(b32.hi);
    assign m_lo   = sel8 ? 64'(b8.lo)  : 64'(b32.lo);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed/unsigned interpretation, then plain 64-bit arithmetic
    function automatic void model(input int w, input logic [1:0] o, input logic [63:0] xi, yi,
                                  inout logic [63:0] h, inout logic [63:0] l, output bit dz);
        logic [63:0] mask;
        logic [63:0] x, y, p;
        longint      sx, sy, q, r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = xi & mask;
        y = yi & mask;
        sx = longint'(x);
        sy = longint'(y);
        if (!o[0] && x[w-1]) sx = longint'(x | ~mask);
        if (!o[0] && y[w-1]) sy = longint'(y | ~mask);
        dz = 1'b0;
        if (!o[1]) begin
            p = 64'(sx) * 64'(sy);
            h = (p >> w) & mask;
            l = p & mask;
        end else if (y == 64'd0) begin
            dz = 1'b1;
        end else begin
            q = sx / sy;
            r = sx % sy;
            h = 64'(r) & mask;
            l = 64'(q) & mask;
        end
    endfunction

    task automatic drive(input logic st, input logic [1:0] o, input logic [63:0] x, y);
        b32.start = sel8 ? 1'b0 : st;
        b8.start  = sel8 ? st : 1'b0;
        b32.op = o;        b8.op = o;
        b32.a  = x[31:0];  b8.a  = x[7:0];
        b32.b  = y[31:0];  b8.b  = y[7:0];
    endtask

    // Issues one operation at the current negedge; returns at the negedge where done is seen.
    task automatic run(input logic [1:0] o, input logic [63:0] x, y, input bit noise,
                       input int abort_at, input string tag);
        int          w;
        int          cyc;
        int          busy_n;
        int          lat;
        bit          dz;
        bit          hold_bad;
        logic [63:0] ph, pl, h, l;
        w  = sel8 ? 8 : 32;
        ph = e_hi[sel8];
        pl = e_lo[sel8];
        h  = ph;
        l  = pl;
        model(w, o, x, y, h, l, dz);
        lat = dz ? 1 : w + 1;
        drive(1'b1, o, x, y);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        cyc = 0;
        busy_n = 0;
        hold_bad = 1'b0;
        check({tag, "_done_low_after_accept"}, 64'(m_done), 64'd0);
        check({tag, "_dz_cleared"}, 64'(m_dz), 64'd0);
        while (!m_done && cyc < 200) begin
            if (m_busy) busy_n++;
            if (m_hi !== ph || m_lo !== pl) hold_bad = 1'b1;
            if (cyc == abort_at) begin
                reset = 1'b1;
                #1;
                check({tag, "_rst_busy"}, 64'(m_busy), 64'd0);
                check({tag, "_rst_done"}, 64'(m_done), 64'd0);
                check({tag, "_rst_hi"}, m_hi, 64'd0);
                check({tag, "_rst_lo"}, m_lo, 64'd0);
                e_hi[0] = '0; e_hi[1] = '0;
                e_lo[0] = '0; e_lo[1] = '0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (noise) drive(1'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            @(negedge clk);
            cyc++;
        end
        drive(1'b0, o, x, y);
        e_hi[sel8] = h;
        e_lo[sel8] = l;
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(lat));
        check({tag, "_busy_at_done"}, 64'(m_busy), 64'd0);
        check({tag, "_hold"}, 64'(hold_bad), 64'd0);
        check({tag, "_hi"}, m_hi, h);
        check({tag, "_lo"}, m_lo, l);
        check({tag, "_div_zero"}, 64'(m_dz), 64'(dz));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [63:0] x, y;
        logic [1:0]  o;
        sel8 = 1'b0;
        e_hi[0] = '0; e_hi[1] = '0;
        e_lo[0] = '0; e_lo[1] = '0;
        reset = 1'b1;
        drive(1'b0, 2'd0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(b32.busy), 64'd0);
        check("reset_done", 64'(b32.done), 64'd0);
        check("reset_hi", 64'(b32.hi), 64'd0);
        check("reset_lo", 64'(b32.lo), 64'd0);
        check("reset_dz", 64'(b32.div_zero), 64'd0);
        check("reset_hi8", 64'(b8.hi), 64'd0);
        reset = 1'b0;

        run(2'b00, 64'hFFFFFFFD, 64'd7, 1'b0, -1, "mult_m3x7");
        check("mult_m3x7_hi_const", m_hi, 64'hFFFFFFFF);
        check("mult_m3x7_lo_const", m_lo, 64'hFFFFFFEB);
        run(2'b01, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, -1, "multu_max");
        check("multu_max_hi_const", m_hi, 64'hFFFFFFFE);
        check("multu_max_lo_const", m_lo, 64'h00000001);
        run(2'b00, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, -1, "mult_m1");
        check("mult_m1_hi_const", m_hi, 64'h00000000);
        check("mult_m1_lo_const", m_lo, 64'h00000001);
        run(2'b10, 64'hFFFFFFF9, 64'd2, 1'b0, -1, "div_m7");
        check("div_m7_lo_const", m_lo, 64'hFFFFFFFD);
        check("div_m7_hi_const", m_hi, 64'hFFFFFFFF);
        run(2'b10, 64'h80000000, 64'hFFFFFFFF, 1'b0, -1, "div_ovf");
        check("div_ovf_lo_const", m_lo, 64'h80000000);
        check("div_ovf_hi_const", m_hi, 64'h0);
        run(2'b11, 64'd59, 64'd6, 1'b0, -1, "divu_59_6");
        check("divu_59_6_hi_const", m_hi, 64'd5);
        check("divu_59_6_lo_const", m_lo, 64'd9);
        run(2'b11, 64'd100, 64'd0, 1'b0, -1, "divu_zero");
        check("divu_zero_flag_const", 64'(m_dz), 64'd1);
        check("divu_zero_hi_const", m_hi, 64'd5);
        check("divu_zero_lo_const", m_lo, 64'd9);
        run(2'b01, 64'($urandom), 64'($urandom), 1'b0, -1, "after_zero");
        run(2'b00, 64'($urandom), 64'($urandom), 1'b1, -1, "noise_mult");
        run(2'b10, 64'($urandom), 64'($urandom_range(1, 1000)), 1'b1, -1, "noise_div");

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            x = (i % 7 == 3) ? 64'h80000000 : 64'($urandom);
            case ($urandom % 6)
                0:       y = 64'd0;
                1:       y = 64'hFFFFFFFF;
                2:       y = 64'd1;
                default: y = 64'($urandom);
            endcase
            run(o, x, y, (i % 3 == 0), -1, "rand32");
        end

        run(2'b01, 64'($urandom), 64'($urandom), 1'b0, 10, "abort");
        check("abort_dz", 64'(b32.div_zero), 64'd0);

        sel8 = 1'b1;
        run(2'b01, 64'hFF, 64'hFF, 1'b0, -1, "multu8");
        check("multu8_hi_const", m_hi, 64'hFE);
        check("multu8_lo_const", m_lo, 64'h01);
        run(2'b10, 64'h80, 64'hFF, 1'b0, -1, "div8_ovf");
        for (int i = 0; i < 12; i++) begin
            o = 2'($urandom);
            x = 64'($urandom);
            y = (i % 4 == 1) ? 64'd0 : 64'($urandom);
            run(o, x, y, (i % 2 == 0), -1, "rand8");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
